// File: rtl/alarm_trigger.sv
// Alarm ring controller: watches for the alarm minute, rings for a bounded
// period, and handles stop/snooze with a guard against re-ringing in the same minute.
module alarm_trigger #(
    parameter int RING_SECS   = 30,
    parameter int SNOOZE_SECS = 300,
    parameter int CNT_W       = 9
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick_1hz,
    input  logic       alarm_en,
    input  logic [3:0] cur_min1,
    input  logic [3:0] cur_min2,
    input  logic [3:0] alarm_min1,
    input  logic [3:0] alarm_min2,
    input  logic       stop_btn,
    input  logic       snooze_btn,
    output logic       ring,
    output logic       beep,
    output logic       snoozing,
    output logic [2:0] state_o
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        DONE    = 3'd1,
        ARMED   = 3'd2,
        RINGING = 3'd3,
        SNOOZE  = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] RING_LAST   = CNT_W'(RING_SECS - 1);
    localparam logic [CNT_W-1:0] SNOOZE_LAST = CNT_W'(SNOOZE_SECS - 1);

    state_t           state;
    logic [CNT_W-1:0] sec_cnt;
    logic             stop_prev;
    logic             snooze_prev;
    logic             match;
    logic             stop_rise;
    logic             snooze_rise;

    // Non-BCD digits never match, even when both sides hold the same value.
    assign match = (cur_min1 <= 4'd9) && (cur_min2 <= 4'd9) &&
                   (alarm_min1 <= 4'd9) && (alarm_min2 <= 4'd9) &&
                   (cur_min1 == alarm_min1) && (cur_min2 == alarm_min2);

    assign stop_rise   = stop_btn & ~stop_prev;
    assign snooze_rise = snooze_btn & ~snooze_prev;

    assign ring     = (state == RINGING);
    assign snoozing = (state == SNOOZE);
    assign state_o  = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            sec_cnt     <= '0;
            beep        <= 1'b0;
            // Held-through-reset buttons must not look like a fresh press.
            stop_prev   <= 1'b1;
            snooze_prev <= 1'b1;
        end else begin
            stop_prev   <= stop_btn;
            snooze_prev <= snooze_btn;
            if (!alarm_en) begin
                state   <= IDLE;
                sec_cnt <= '0;
                beep    <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        state   <= DONE;
                        sec_cnt <= '0;
                        beep    <= 1'b0;
                    end
                    DONE: begin
                        beep <= 1'b0;
                        if (!match) begin
                            state   <= ARMED;
                            sec_cnt <= '0;
                        end
                    end
                    ARMED: begin
                        if (match) begin
                            state   <= RINGING;
                            sec_cnt <= '0;
                            beep    <= 1'b1;
                        end else begin
                            beep <= 1'b0;
                        end
                    end
                    RINGING: begin
                        if (stop_rise) begin
                            state   <= DONE;
                            sec_cnt <= '0;
                            beep    <= 1'b0;
                        end else if (snooze_rise) begin
                            state   <= SNOOZE;
                            sec_cnt <= '0;
                            beep    <= 1'b0;
                        end else if (tick_1hz) begin
                            if (sec_cnt == RING_LAST) begin
                                state   <= DONE;
                                sec_cnt <= '0;
                                beep    <= 1'b0;
                            end else begin
                                sec_cnt <= sec_cnt + 1'b1;
                                beep    <= ~beep;
                            end
                        end
                    end
                    SNOOZE: begin
                        // Repeated snooze presses do not restart the timer.
                        if (stop_rise) begin
                            state   <= DONE;
                            sec_cnt <= '0;
                            beep    <= 1'b0;
                        end else if (tick_1hz) begin
                            if (sec_cnt == SNOOZE_LAST) begin
                                state   <= RINGING;
                                sec_cnt <= '0;
                                beep    <= 1'b1;
                            end else begin
                                sec_cnt <= sec_cnt + 1'b1;
                                beep    <= 1'b0;
                            end
                        end else begin
                            beep <= 1'b0;
                        end
                    end
                    default: begin
                        state   <= IDLE;
                        sec_cnt <= '0;
                        beep    <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_alarm_trigger.sv
// Bench for alarm_trigger: directed scenarios then random stimulus, all compared
// against a per-cycle behavioural model of the alarm rules.
module tb_alarm_trigger;

    localparam int RING_SECS   = 4;
    localparam int SNOOZE_SECS = 6;

    localparam int S_IDLE   = 0;
    localparam int S_DONE   = 1;
    localparam int S_ARMED  = 2;
    localparam int S_RING   = 3;
    localparam int S_SNOOZE = 4;

    logic       clk;
    logic       rst_n;
    logic       tick_1hz;
    logic       alarm_en;
    logic [3:0] cur_min1;
    logic [3:0] cur_min2;
    logic [3:0] alarm_min1;
    logic [3:0] alarm_min2;
    logic       stop_btn;
    logic       snooze_btn;
    logic       ring;
    logic       beep;
    logic       snoozing;
    logic [2:0] state_o;

    int errors = 0;
    int checks = 0;

    // Model: which state we are in and how many ticks have elapsed in it.
    int m_state;
    int m_elapsed;
    bit m_stop_prev;
    bit m_snz_prev;

    alarm_trigger #(
        .RING_SECS  (RING_SECS),
        .SNOOZE_SECS(SNOOZE_SECS),
        .CNT_W      (9)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .tick_1hz  (tick_1hz),
        .alarm_en  (alarm_en),
        .cur_min1  (cur_min1),
        .cur_min2  (cur_min2),
        .alarm_min1(alarm_min1),
        .alarm_min2(alarm_min2),
        .stop_btn  (stop_btn),
        .snooze_btn(snooze_btn),
        .ring      (ring),
        .beep      (beep),
        .snoozing  (snoozing),
        .state_o   (state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state     = S_IDLE;
        m_elapsed   = 0;
        m_stop_prev = 1'b1;
        m_snz_prev  = 1'b1;
    endtask

    // Apply the alarm rules for one clock edge using the inputs currently driven.
    task automatic model_update();
        bit match, sr, nr;
        match = (cur_min1 <= 9) && (cur_min2 <= 9) && (alarm_min1 <= 9) && (alarm_min2 <= 9)
                && (cur_min1 == alarm_min1) && (cur_min2 == alarm_min2);
        sr = stop_btn && !m_stop_prev;
        nr = snooze_btn && !m_snz_prev;
        m_stop_prev = stop_btn;
        m_snz_prev  = snooze_btn;
        if (!alarm_en) begin
            m_state   = S_IDLE;
            m_elapsed = 0;
        end else begin
            case (m_state)
                S_IDLE:  m_state = S_DONE;
                S_DONE:  if (!match) m_state = S_ARMED;
                S_ARMED: if (match) begin m_state = S_RING; m_elapsed = 0; end
                S_RING: begin
                    if (sr) m_state = S_DONE;
                    else if (nr) begin m_state = S_SNOOZE; m_elapsed = 0; end
                    else if (tick_1hz) begin
                        m_elapsed++;
                        if (m_elapsed == RING_SECS) m_state = S_DONE;
                    end
                end
                S_SNOOZE: begin
                    if (sr) m_state = S_DONE;
                    else if (tick_1hz) begin
                        m_elapsed++;
                        if (m_elapsed == SNOOZE_SECS) begin m_state = S_RING; m_elapsed = 0; end
                    end
                end
                default: m_state = S_IDLE;
            endcase
        end
    endtask

    task automatic check_outputs(input string tag);
        bit exp_ring;
        exp_ring = (m_state == S_RING);
        check({tag, ".state"}, 32'(state_o), 32'(m_state));
        check({tag, ".ring"}, 32'(ring), 32'(exp_ring));
        // Beep starts high on entry and flips on every counted tick.
        check({tag, ".beep"}, 32'(beep), 32'(exp_ring && (m_elapsed % 2 == 0)));
        check({tag, ".snoozing"}, 32'(snoozing), 32'(m_state == S_SNOOZE));
    endtask

    task automatic step(input string tag);
        model_update();
        @(posedge clk);
        #1;
        check_outputs(tag);
    endtask

    task automatic pulse_tick(input string tag);
        tick_1hz = 1'b1;
        step(tag);
        tick_1hz = 1'b0;
    endtask

    task automatic set_cur(input logic [3:0] a, input logic [3:0] b);
        cur_min1 = a;
        cur_min2 = b;
    endtask

    initial begin
        rst_n = 1'b0; tick_1hz = 1'b0; alarm_en = 1'b0;
        cur_min1 = 4'd0; cur_min2 = 4'd0; alarm_min1 = 4'd3; alarm_min2 = 4'd5;
        stop_btn = 1'b1; snooze_btn = 1'b0;
        model_reset();

        // Reset release with stop held.
        repeat (2) @(posedge clk);
        #1;
        check_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        step("post_reset");
        $display("txn reset_release state=%0d ring=%0b beep=%0b", state_o, ring, beep);

        // Enable during the alarm minute: must not ring straight away.
        alarm_en = 1'b1;
        set_cur(4'd3, 4'd5);
        step("en_idle_done");
        step("en_stay_done");
        step("en_stay_done2");
        set_cur(4'd3, 4'd6);
        step("arm");
        set_cur(4'd3, 4'd5);
        step("ring_start");
        $display("txn arm_and_ring state=%0d ring=%0b", state_o, ring);

        // Ring timeout; held stop from reset still never looks like an edge.
        for (int i = 0; i < RING_SECS; i++) pulse_tick("ring_tick");
        repeat (3) step("done_hold");
        $display("txn ring_timeout state=%0d ring=%0b", state_o, ring);

        // Snooze, with a second snooze press mid-snooze that must be ignored.
        stop_btn = 1'b0;
        set_cur(4'd3, 4'd6);
        step("rearm");
        set_cur(4'd3, 4'd5);
        step("ring2");
        snooze_btn = 1'b1;
        step("snooze_enter");
        snooze_btn = 1'b0;
        for (int i = 0; i < 3; i++) pulse_tick("snooze_tick");
        snooze_btn = 1'b1;
        step("snooze_again");
        snooze_btn = 1'b0;
        step("snooze_idle");
        for (int i = 0; i < SNOOZE_SECS - 3; i++) pulse_tick("snooze_tick2");
        $display("txn snooze_rering state=%0d ring=%0b beep=%0b", state_o, ring, beep);

        // Stop and snooze edges together with a tick: stop wins.
        stop_btn = 1'b1; snooze_btn = 1'b1; tick_1hz = 1'b1;
        step("stop_wins");
        stop_btn = 1'b0; snooze_btn = 1'b0; tick_1hz = 1'b0;
        set_cur(4'd3, 4'd6);
        step("rearm3");
        set_cur(4'd3, 4'd5);
        step("ring3");
        snooze_btn = 1'b1;
        step("snooze3");
        snooze_btn = 1'b0;
        alarm_en = 1'b0;
        step("disable_in_snooze");
        $display("txn stop_and_disable state=%0d snoozing=%0b", state_o, snoozing);

        // Invalid digits never match.
        alarm_en = 1'b1;
        set_cur(4'd3, 4'd6);
        step("inv_done");
        step("inv_armed");
        set_cur(4'hA, 4'hA); alarm_min1 = 4'hA; alarm_min2 = 4'hA;
        repeat (3) step("inv_no_ring");
        $display("txn invalid_digits state=%0d ring=%0b", state_o, ring);

        // Asynchronous reset in the middle of a ring.
        alarm_min1 = 4'd3; alarm_min2 = 4'd5;
        set_cur(4'd3, 4'd5);
        step("async_ring");
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        step("async_release");
        $display("txn async_reset state=%0d ring=%0b", state_o, ring);

        // Random stimulus.
        for (int i = 0; i < 600; i++) begin
            int r;
            alarm_en = ($urandom_range(99) < 97);
            r = $urandom_range(9);
            if (r < 4) set_cur(alarm_min1, alarm_min2);
            else if (r < 8) set_cur(4'($urandom_range(9)), 4'($urandom_range(9)));
            else set_cur(4'($urandom_range(15)), 4'($urandom_range(15)));
            if ($urandom_range(99) < 3) begin
                alarm_min1 = 4'($urandom_range(11));
                alarm_min2 = 4'($urandom_range(11));
            end
            tick_1hz = ($urandom_range(99) < 35);
            if ($urandom_range(99) < 4) stop_btn = ~stop_btn;
            if ($urandom_range(99) < 8) snooze_btn = ~snooze_btn;
            step("rand");
        end
        tick_1hz = 1'b0;
        $display("txn random_done cycles=600");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
